// File: rtl/line_ctrl_pkg.sv
// line_ctrl_pkg: shared FSM type, widths and saturation helpers for line steering
package line_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, COAST = 2'd2, SEARCH = 2'd3} state_t;
    localparam int DUTY_W = 16;
    localparam int CALC_W = 18;
    typedef logic signed [CALC_W-1:0] calc_t;
    function automatic calc_t sat(input calc_t v, input calc_t lim);
        return (v > lim) ? lim : (v < -lim) ? -lim : v;
    endfunction
    function automatic logic [DUTY_W-1:0] clamp(input calc_t v, input calc_t hi);
        return DUTY_W'(v[CALC_W-1] ? calc_t'(0) : (v > hi) ? hi : v);
    endfunction
endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: free-running PWM whose duty shadow is only taken at the period wrap
module pwm_gen import line_ctrl_pkg::*; #(
    parameter int PERIOD = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [DUTY_W-1:0] shadow,
    output logic              pwm
);
    localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PERIOD - 1);
    logic [DUTY_W-1:0] cnt, active;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            cnt <= (cnt == LAST) ? '0 : cnt + DUTY_W'(1);
            if (cnt == LAST) active <= shadow;
            pwm <= cnt < active;
        end
    end
endmodule

// File: rtl/line_steer_ctrl.sv
// line_steer_ctrl: PD steering from line centroid to differential motor PWM,
// with a coast-then-search recovery when the line is lost.
module line_steer_ctrl import line_ctrl_pkg::*; #(
    parameter int IMG_W        = 640,
    parameter int PWM_PERIOD   = 1000,
    parameter int BASE_DUTY    = 600,
    parameter int KP_SHIFT     = 2,
    parameter int KD_SHIFT     = 3,
    parameter int CORR_MAX     = 400,
    parameter int LOST_TIMEOUT = 500000,
    parameter int SEARCH_DUTY  = 300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [10:0] centroid_x,
    input  logic        line_valid,
    input  logic        line_lost,
    output logic        pwm_left,
    output logic        pwm_right,
    output logic [15:0] duty_left,
    output logic [15:0] duty_right,
    output logic        cmd_valid,
    output logic [1:0]  state_o
);
    localparam logic [10:0]        CX_MAX = 11'(IMG_W - 1);
    localparam logic signed [11:0] MID    = 12'(IMG_W / 2);
    localparam int                 TMR_W  = $clog2(LOST_TIMEOUT + 1);
    localparam logic [DUTY_W-1:0]  SD     = DUTY_W'(SEARCH_DUTY);
    state_t state;
    logic signed [11:0] err_prev, err_s1, err_new;
    logic signed [12:0] derr_s1;
    calc_t corr_s2, pd, left_c, right_c;
    logic v1, v2, acc, clear;
    logic [10:0] cx;
    logic [TMR_W-1:0] tmr;
    assign acc     = en && line_valid && !line_lost && state != IDLE;
    assign cx      = (centroid_x > CX_MAX) ? CX_MAX : centroid_x;
    assign err_new = $signed({1'b0, cx}) - MID;
    assign pd      = calc_t'(err_s1 >>> KP_SHIFT) + calc_t'(derr_s1 >>> KD_SHIFT);
    assign left_c  = calc_t'(BASE_DUTY) + corr_s2;
    assign right_c = calc_t'(BASE_DUTY) - corr_s2;
    assign clear   = !en || state == IDLE;
    assign state_o = state;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            err_prev   <= '0;
            err_s1     <= '0;
            derr_s1    <= '0;
            corr_s2    <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            tmr        <= '0;
            duty_left  <= '0;
            duty_right <= '0;
            cmd_valid  <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            v1        <= acc;
            v2        <= v1;
            if (acc) begin
                err_s1   <= err_new;
                derr_s1  <= (state == SEARCH) ? '0 : 13'(err_new) - 13'(err_prev);
                err_prev <= err_new;
            end
            if (v1) corr_s2 <= sat(pd, calc_t'(CORR_MAX));
            if (!en) begin
                state      <= IDLE;
                v1         <= 1'b0;
                v2         <= 1'b0;
                duty_left  <= '0;
                duty_right <= '0;
            end else begin
                case (state)
                    IDLE: state <= TRACK;
                    TRACK: begin
                        // results landing outside TRACK are stale and dropped
                        if (v2) begin
                            duty_left  <= clamp(left_c, calc_t'(PWM_PERIOD));
                            duty_right <= clamp(right_c, calc_t'(PWM_PERIOD));
                            cmd_valid  <= 1'b1;
                        end
                        if (line_lost) begin
                            state <= COAST;
                            tmr   <= '0;
                        end
                    end
                    COAST: begin
                        if (acc) state <= TRACK;
                        else if (tmr == TMR_W'(LOST_TIMEOUT - 1)) begin
                            state      <= SEARCH;
                            duty_left  <= err_prev[11] ? '0 : SD;
                            duty_right <= err_prev[11] ? SD : '0;
                            cmd_valid  <= 1'b1;
                        end else tmr <= tmr + TMR_W'(1);
                    end
                    SEARCH: if (acc) state <= TRACK;
                endcase
            end
        end
    end
    pwm_gen #(.PERIOD(PWM_PERIOD)) u_pwm_left (
        .clk(clk), .rst_n(rst_n), .clear(clear), .shadow(duty_left), .pwm(pwm_left)
    );
    pwm_gen #(.PERIOD(PWM_PERIOD)) u_pwm_right (
        .clk(clk), .rst_n(rst_n), .clear(clear), .shadow(duty_right), .pwm(pwm_right)
    );
endmodule

// File: tb/tb_line_steer_ctrl.sv
// tb_line_steer_ctrl: directed and random stimulus against a transaction-level model
module tb_line_steer_ctrl;
    localparam int IMG_W = 640, PERIOD = 1000, BASE = 900, KP = 2, KD = 3;
    localparam int CMAX = 150, LT = 100, SD = 300;
    logic clk = 0, rst_n = 0, en = 0, line_valid = 0, line_lost = 0;
    logic [10:0] centroid_x = 0;
    logic pwm_left, pwm_right, cmd_valid;
    logic [15:0] duty_left, duty_right;
    logic [1:0] state_o;
    int total = 0, bad = 0;
    int m_state, m_errp, m_dl, m_dr, m_cmd, m_tmr;
    typedef struct {int l; int r; int rem;} pend_t;
    pend_t q[$];

    line_steer_ctrl #(.IMG_W(IMG_W), .PWM_PERIOD(PERIOD), .BASE_DUTY(BASE), .KP_SHIFT(KP),
        .KD_SHIFT(KD), .CORR_MAX(CMAX), .LOST_TIMEOUT(LT), .SEARCH_DUTY(SD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .centroid_x(centroid_x), .line_valid(line_valid),
        .line_lost(line_lost), .pwm_left(pwm_left), .pwm_right(pwm_right), .duty_left(duty_left),
        .duty_right(duty_right), .cmd_valid(cmd_valid), .state_o(state_o));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        return a >= 0 ? a / b : -((-a + b - 1) / b);
    endfunction

    function automatic int lim(input int v, input int lo, input int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_errp = 0; m_dl = 0; m_dr = 0; m_cmd = 0; m_tmr = 0;
        q.delete();
    endtask

    task automatic model_edge();
        bit acc;
        int e, d, c;
        pend_t p;
        m_cmd = 0;
        if (!en) begin
            m_state = 0; m_dl = 0; m_dr = 0;
            q.delete();
            return;
        end
        acc = line_valid && !line_lost && m_state != 0;
        if (q.size() > 0 && q[0].rem == 0) begin
            if (m_state == 1) begin m_dl = q[0].l; m_dr = q[0].r; m_cmd = 1; end
            void'(q.pop_front());
        end
        foreach (q[i]) q[i].rem = q[i].rem - 1;
        if (acc) begin
            e = lim(int'(centroid_x), 0, IMG_W - 1) - IMG_W / 2;
            d = (m_state == 3) ? 0 : e - m_errp;
            c = lim(fdiv(e, 1 << KP) + fdiv(d, 1 << KD), -CMAX, CMAX);
            p.l = lim(BASE + c, 0, PERIOD);
            p.r = lim(BASE - c, 0, PERIOD);
            p.rem = 1;
            q.push_back(p);
        end
        case (m_state)
            0: m_state = 1;
            1: if (line_lost) begin m_state = 2; m_tmr = 0; end
            2: if (acc) m_state = 1;
               else if (m_tmr == LT - 1) begin
                   m_state = 3; m_cmd = 1;
                   m_dl = m_errp < 0 ? 0 : SD;
                   m_dr = m_errp < 0 ? SD : 0;
               end else m_tmr++;
            default: if (acc) m_state = 1;
        endcase
        if (acc) m_errp = e;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk); #1;
        check("state", int'(state_o), m_state);
        check("duty_left", int'(duty_left), m_dl);
        check("duty_right", int'(duty_right), m_dr);
        check("cmd_valid", int'(cmd_valid), m_cmd);
    endtask

    task automatic pulse(input int x);
        centroid_x = 11'(x); line_valid = 1;
        step();
        line_valid = 0;
        repeat (3) step();
    endtask

    task automatic pwm_count(output int nl, output int nr);
        nl = 0; nr = 0;
        repeat (1100) step();
        for (int i = 0; i < PERIOD; i++) begin
            step();
            nl += int'(pwm_left);
            nr += int'(pwm_right);
        end
    endtask

    initial begin
        int nl, nr;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(state_o), 0);
        check("rst_duty_l", int'(duty_left), 0);
        check("rst_pwm_l", int'(pwm_left), 0);
        check("rst_cmd", int'(cmd_valid), 0);
        rst_n = 1;
        step();
        en = 1;
        step();
        check("en_track", int'(state_o), 1);
        pulse(320);
        check("center_l", int'(duty_left), BASE);
        check("center_r", int'(duty_right), BASE);
        pwm_count(nl, nr);
        check("center_pwm_l", nl, BASE);
        check("center_pwm_r", nr, BASE);
        pulse(400);
        check("pd1_l", int'(duty_left), 930);
        check("pd1_r", int'(duty_right), 870);
        pulse(400);
        check("pd2_l", int'(duty_left), 920);
        check("pd2_r", int'(duty_right), 880);
        pulse(639);
        check("clamp_l", int'(duty_left), 1000);
        check("clamp_r", int'(duty_right), 792);
        pwm_count(nl, nr);
        check("clamp_pwm_l", nl, PERIOD);
        check("clamp_pwm_r", nr, 792);
        pulse(0);
        check("sat_l", int'(duty_left), 750);
        check("sat_r", int'(duty_right), 1000);
        line_lost = 1;
        step();
        check("coast", int'(state_o), 2);
        repeat (LT + 1) step();
        check("search", int'(state_o), 3);
        check("search_l", int'(duty_left), 0);
        check("search_r", int'(duty_right), SD);
        pwm_count(nl, nr);
        check("search_pwm_l", nl, 0);
        check("search_pwm_r", nr, SD);
        line_lost = 0;
        pulse(320);
        check("reacq_state", int'(state_o), 1);
        check("reacq_l", int'(duty_left), BASE);
        check("reacq_r", int'(duty_right), BASE);
        centroid_x = 11'd500; line_valid = 1; line_lost = 1;
        step();
        line_valid = 0; line_lost = 0;
        repeat (3) step();
        check("both_coast", int'(state_o), 2);
        check("both_hold", int'(duty_left), BASE);
        repeat (37) step();
        en = 0;
        step();
        check("endrop_pwm_l", int'(pwm_left), 0);
        check("endrop_pwm_r", int'(pwm_right), 0);
        check("endrop_idle", int'(state_o), 0);
        for (int i = 0; i < 600; i++) begin
            en = ($urandom % 80) != 0;
            line_valid = ($urandom % 3) == 0;
            line_lost = ($urandom % 8) == 0;
            centroid_x = ($urandom % 4 == 0) ? 11'($urandom_range(640, 2047)) : 11'($urandom_range(0, 639));
            step();
        end
        en = 1; line_valid = 0; line_lost = 0;
        step();
        pulse(320);
        repeat (1100) step();
        #3 rst_n = 0;
        #1;
        check("arst_pwm_l", int'(pwm_left), 0);
        check("arst_pwm_r", int'(pwm_right), 0);
        check("arst_state", int'(state_o), 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        step();
        check("rel_state", int'(state_o), 1);
        check("rel_duty_l", int'(duty_left), 0);
        check("rel_duty_r", int'(duty_right), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
